imem_boot_ctrl: RTL



---
 rtl/imem_boot_ctrl_if.sv | 25 ++
 rtl/imem_boot_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/imem_boot_ctrl_if.sv
// Instruction-memory boot controller bus bundle.
//   rx_valid / rx_data / rx_ready : byte-serial loader stream (one byte per handshake)
//   mem_addr / mem_we / mem_wdata : single-port instruction memory word port
// The master modport is the controller side: it accepts loader bytes and
// drives the memory port. The slave modport is the loader / memory side.
interface imem_boot_ctrl_if #(
  parameter int AW = 6
);
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [31:0]   mem_wdata;

  modport master (
    input  rx_valid, rx_data,
    output rx_ready, mem_addr, mem_we, mem_wdata
  );

  modport slave (
    output rx_valid, rx_data,
    input  rx_ready, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/imem_boot_ctrl.sv
// Boot/load controller sharing a single-port instruction memory between
// core fetch and a byte-serial program loader.
//   clk, rst_n      : clock, asynchronous active-low reset
//   boot_req        : one-cycle load request (honoured only in RUN)
//   word_count      : words to load, sampled with boot_req
//   boot_abort      : cancel an in-progress load
//   pc_in           : core fetch PC (byte address, word aligned)
//   bus             : loader byte stream in, memory word port out
//   core_run        : core may advance its PC
//   busy            : load in progress
//   done            : one-cycle pulse when a load completes
//   err             : sticky error (bad word_count or abort), cleared by a good boot_req
// Bytes are packed little-endian into 32-bit words and written from word 0 upward.
module imem_boot_ctrl #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 boot_req,
  input  logic [AW:0]          word_count,
  input  logic                 boot_abort,
  input  logic [31:0]          pc_in,
  imem_boot_ctrl_if.master     bus,
  output logic                 core_run,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  typedef enum logic [1:0] {RUN, LOAD, WRITE, RELEASE} state_t;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_W   = (AW+1)'(1);

  state_t        state, state_nxt;
  logic [AW-1:0] wr_ptr;
  logic [1:0]    byte_cnt;
  logic [AW:0]   words_left;
  logic [31:0]   word_reg;
  logic          err_q;

  logic          start_load;
  logic          accept;
  logic          do_write;
  logic          set_err;
  logic          rx_ready_c;
  logic          mem_we_c;

  // PC bits outside the word index play no part in fetch addressing.
  logic          unused_pc;
  assign unused_pc = ^{pc_in[31:AW+2], pc_in[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    start_load = 1'b0;
    accept     = 1'b0;
    do_write   = 1'b0;
    set_err    = 1'b0;
    rx_ready_c = 1'b0;
    mem_we_c   = 1'b0;
    core_run   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      RUN: begin
        core_run = 1'b1;
        // boot_req takes priority over a simultaneous boot_abort here.
        if (boot_req) begin
          if (word_count != '0 && word_count <= DEPTH_W) begin
            start_load = 1'b1;
            state_nxt  = LOAD;
          end else begin
            set_err = 1'b1;
          end
        end
      end
      LOAD: begin
        busy       = 1'b1;
        rx_ready_c = 1'b1;
        accept     = bus.rx_valid;
        // Abort beats a simultaneous 4th byte: the word is never written.
        if (boot_abort) begin
          set_err   = 1'b1;
          state_nxt = RUN;
        end else if (bus.rx_valid && byte_cnt == 2'd3) begin
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        busy     = 1'b1;
        mem_we_c = 1'b1;
        do_write = 1'b1;
        // The write in this cycle still lands even when aborting.
        if (boot_abort) begin
          set_err   = 1'b1;
          state_nxt = RUN;
        end else if (words_left == ONE_W) begin
          state_nxt = RELEASE;
        end else begin
          state_nxt = LOAD;
        end
      end
      RELEASE: begin
        done      = 1'b1;
        state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      byte_cnt   <= '0;
      words_left <= '0;
      word_reg   <= '0;
    end else begin
      if (start_load) begin
        wr_ptr     <= '0;
        byte_cnt   <= '0;
        words_left <= word_count;
      end
      if (accept) begin
        word_reg[8*byte_cnt +: 8] <= bus.rx_data;
        byte_cnt                  <= byte_cnt + 2'd1;
      end
      if (do_write) begin
        wr_ptr     <= wr_ptr + 1'b1;
        words_left <= words_left - ONE_W;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          err_q <= 1'b0;
    else if (set_err)    err_q <= 1'b1;
    else if (start_load) err_q <= 1'b0;
  end

  assign err           = err_q;
  assign bus.rx_ready  = rx_ready_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_wdata = word_reg;
  // Fetch owns the memory in RUN; the loader's write pointer owns it otherwise.
  assign bus.mem_addr  = (state == RUN) ? pc_in[AW+1:2] : wr_ptr;

endmodule
